// File: rtl/pixel_pair_feeder_pkg.sv
// Shared definitions for the pixel pair feeder: pixel width and the
// neural_core mode encodings.
package pixel_pair_feeder_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    MODE_BLEND  = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_BRIGHT = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

endpackage

// File: rtl/pixel_pair_feeder_if.sv
// Bundles the two pixel streams, the config port and the neural_core-facing
// outputs. The master side is the environment, the slave side the feeder.
interface pixel_pair_feeder_if #(
  parameter int CW = 16
);
  import pixel_pair_feeder_pkg::*;

  logic [PIX_W-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [PIX_W-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [1:0]       cfg_mode;
  logic [PIX_W-1:0] cfg_param;
  logic             cfg_load;
  logic             hold;
  logic [PIX_W-1:0] pix_t;
  logic [PIX_W-1:0] pix_t1;
  logic [1:0]       mode_o;
  logic [PIX_W-1:0] param_o;
  logic             pair_valid;
  logic             res_valid;
  logic             frame_end;
  logic [CW-1:0]    pix_count;

  modport master (
    output a_data, a_valid, b_data, b_valid, cfg_mode, cfg_param, cfg_load, hold,
    input  a_ready, b_ready, pix_t, pix_t1, mode_o, param_o,
           pair_valid, res_valid, frame_end, pix_count
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, cfg_mode, cfg_param, cfg_load, hold,
    output a_ready, b_ready, pix_t, pix_t1, mode_o, param_o,
           pair_valid, res_valid, frame_end, pix_count
  );

endinterface

// File: rtl/pixel_pair_feeder_pix_fifo.sv
// Small synchronous pixel FIFO; pushes to a full FIFO are dropped (no
// pass-through), push and pop may occur together.
module pix_fifo
  import pixel_pair_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic             pop_i,
  output logic [PIX_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pixel_pair_feeder.sv
// Pairs buffered A/B pixel streams for neural_core, switches config only at
// frame boundaries and regenerates the valid lost in neural_core's register.
module pixel_pair_feeder
  import pixel_pair_feeder_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FRAME_PIXELS = 1024,
  parameter int CW           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pixel_pair_feeder_if.slave bus
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  logic             aFull, aEmpty, bFull, bEmpty;
  logic [PIX_W-1:0] aHead, bHead;
  logic             issue, aPop, bPop;
  mode_e            effMode;
  logic [PIX_W-1:0] effParam;

  mode_e            modeOut_q, modeOut_d, shadowMode_q, shadowMode_d;
  logic [PIX_W-1:0] paramOut_q, paramOut_d, shadowParam_q, shadowParam_d;
  logic             pending_q, pending_d;
  logic [CW-1:0]    nextIdx_q, nextIdx_d, pixCount_q, pixCount_d;
  logic [PIX_W-1:0] pixT_q, pixT_d, pixT1_q, pixT1_d;
  logic             pairValid_q, resValid_q;

  pix_fifo #(.DEPTH(DEPTH)) uFifoA (
    .clk(clk), .rst_n(rst_n), .push_i(bus.a_valid), .data_i(bus.a_data), .pop_i(aPop),
    .head_o(aHead), .full_o(aFull), .empty_o(aEmpty)
  );

  pix_fifo #(.DEPTH(DEPTH)) uFifoB (
    .clk(clk), .rst_n(rst_n), .push_i(bus.b_valid), .data_i(bus.b_data), .pop_i(bPop),
    .head_o(bHead), .full_o(bFull), .empty_o(bEmpty)
  );

  // The last issued config is the active one; a pending shadow takes over
  // only on the issue of a frame's first pixel.
  always_comb begin
    effMode  = modeOut_q;
    effParam = paramOut_q;
    if (pending_q && nextIdx_q == '0) begin
      effMode  = shadowMode_q;
      effParam = shadowParam_q;
    end
    issue = !bus.hold && !aEmpty && (effMode != MODE_BLEND || !bEmpty);
    aPop  = issue;
    bPop  = issue && (effMode == MODE_BLEND);
  end

  always_comb begin
    modeOut_d     = modeOut_q;
    paramOut_d    = paramOut_q;
    shadowMode_d  = shadowMode_q;
    shadowParam_d = shadowParam_q;
    pending_d     = pending_q;
    nextIdx_d     = nextIdx_q;
    pixCount_d    = pixCount_q;
    pixT_d        = pixT_q;
    pixT1_d       = pixT1_q;
    if (issue) begin
      pixT_d     = aHead;
      pixT1_d    = (effMode == MODE_BLEND) ? bHead : '0;
      modeOut_d  = effMode;
      paramOut_d = effParam;
      pixCount_d = nextIdx_q;
      nextIdx_d  = (nextIdx_q == LAST_IDX) ? '0 : nextIdx_q + CW'(1);
      if (nextIdx_q == '0) pending_d = 1'b0;
    end
    // A same-cycle load must survive the index-0 clear above.
    if (bus.cfg_load) begin
      shadowMode_d  = mode_e'(bus.cfg_mode);
      shadowParam_d = bus.cfg_param;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modeOut_q     <= MODE_BLEND;
      paramOut_q    <= '0;
      shadowMode_q  <= MODE_BLEND;
      shadowParam_q <= '0;
      pending_q     <= 1'b0;
      nextIdx_q     <= '0;
      pixCount_q    <= '0;
      pixT_q        <= '0;
      pixT1_q       <= '0;
      pairValid_q   <= 1'b0;
      resValid_q    <= 1'b0;
    end else begin
      modeOut_q     <= modeOut_d;
      paramOut_q    <= paramOut_d;
      shadowMode_q  <= shadowMode_d;
      shadowParam_q <= shadowParam_d;
      pending_q     <= pending_d;
      nextIdx_q     <= nextIdx_d;
      pixCount_q    <= pixCount_d;
      pixT_q        <= pixT_d;
      pixT1_q       <= pixT1_d;
      pairValid_q   <= issue;
      resValid_q    <= pairValid_q;
    end
  end

  assign bus.a_ready    = !aFull;
  assign bus.b_ready    = !bFull;
  assign bus.pix_t      = pixT_q;
  assign bus.pix_t1     = pixT1_q;
  assign bus.mode_o     = modeOut_q;
  assign bus.param_o    = paramOut_q;
  assign bus.pair_valid = pairValid_q;
  assign bus.res_valid  = resValid_q;
  assign bus.frame_end  = pairValid_q && (pixCount_q == LAST_IDX);
  assign bus.pix_count  = pixCount_q;

endmodule

// File: tb/tb_pixel_pair_feeder.sv
// Scoreboard bench for pixel_pair_feeder: a queue-based reference model
// predicts each issue, a negedge monitor compares what the DUT presents.
module tb_pixel_pair_feeder;
  import pixel_pair_feeder_pkg::*;

  localparam int DEPTH = 4;
  localparam int FP    = 4;
  localparam int CW    = 16;

  typedef struct {
    logic [7:0] t;
    logic [7:0] t1;
    logic [1:0] m;
    logic [7:0] p;
    int         idx;
  } exp_t;

  typedef struct {
    logic [7:0] t;
    logic [7:0] t1;
    logic [1:0] m;
    logic [7:0] p;
    int         idx;
    logic       fe;
    int         cyc;
  } obs_t;

  logic clk;
  logic rst_n;
  pixel_pair_feeder_if #(.CW(CW)) bus ();

  pixel_pair_feeder #(.DEPTH(DEPTH), .FRAME_PIXELS(FP), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;
  int cyc  = 0;

  // Reference model state: stream contents, config and frame position.
  logic [7:0] mA[$];
  logic [7:0] mB[$];
  logic [1:0] mAct, mSh;
  logic [7:0] pAct, pSh;
  bit         mPend;
  int         mIdx;
  bit         mPV, mRV;
  exp_t       expQ[$];
  exp_t       lastExp;
  obs_t       obs[$];
  bit         aAccLast, bAccLast;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin : model
    bit aAcc, bAcc, iss;
    logic [1:0] em;
    logic [7:0] ep;
    exp_t e;
    if (!rst_n) begin
      mA.delete(); mB.delete(); expQ.delete();
      mAct = 0; mSh = 0; pAct = 0; pSh = 0; mPend = 0; mIdx = 0; mPV = 0; mRV = 0;
    end else begin
      aAcc = bus.a_valid && (mA.size() < DEPTH);
      bAcc = bus.b_valid && (mB.size() < DEPTH);
      em = mAct; ep = pAct;
      if (mIdx == 0 && mPend) begin em = mSh; ep = pSh; end
      iss = !bus.hold && mA.size() > 0 && (em != 2'b00 || mB.size() > 0);
      mRV = mPV;
      mPV = iss;
      if (iss) begin
        e.t   = mA.pop_front();
        e.t1  = (em == 2'b00) ? mB.pop_front() : 8'd0;
        e.m   = em;
        e.p   = ep;
        e.idx = mIdx;
        mAct = em; pAct = ep;
        if (mIdx == 0) mPend = 0;
        mIdx = (mIdx + 1) % FP;
        expQ.push_back(e);
      end
      if (bus.cfg_load) begin mSh = bus.cfg_mode; pSh = bus.cfg_param; mPend = 1; end
      if (aAcc) mA.push_back(bus.a_data);
      if (bAcc) mB.push_back(bus.b_data);
    end
  end

  always @(negedge clk) begin : monitor
    obs_t o;
    if (!rst_n) begin
      lastExp = '{t: 0, t1: 0, m: 0, p: 0, idx: 0};
    end else begin
      checkOutput("pair_valid", bus.pair_valid, mPV);
      checkOutput("res_valid", bus.res_valid, mRV);
      checkOutput("a_ready", bus.a_ready, mA.size() < DEPTH);
      checkOutput("b_ready", bus.b_ready, mB.size() < DEPTH);
      if (bus.pair_valid) begin
        nVec++;
        if (expQ.size() == 0) begin
          nBad++;
          $display("[TB] FAIL unexpected_pair: got pix_t=%0d, expected no issue", bus.pix_t);
        end else begin
          lastExp = expQ.pop_front();
        end
        o = '{t: bus.pix_t, t1: bus.pix_t1, m: bus.mode_o, p: bus.param_o,
              idx: int'(bus.pix_count), fe: bus.frame_end, cyc: cyc};
        obs.push_back(o);
      end
      checkOutput("pix_t", bus.pix_t, lastExp.t);
      checkOutput("pix_t1", bus.pix_t1, lastExp.t1);
      checkOutput("mode_o", bus.mode_o, lastExp.m);
      checkOutput("param_o", bus.param_o, lastExp.p);
      checkOutput("pix_count", bus.pix_count, lastExp.idx);
      checkOutput("frame_end", bus.frame_end, mPV && lastExp.idx == FP - 1);
    end
  end

  task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic bv,
                               input logic [7:0] bd, input logic hd, input logic ld,
                               input logic [1:0] md, input logic [7:0] pm);
    bus.a_valid = av; bus.a_data = ad; bus.b_valid = bv; bus.b_data = bd;
    bus.hold = hd; bus.cfg_load = ld; bus.cfg_mode = md; bus.cfg_param = pm;
    aAccLast = av && bus.a_ready;
    bAccLast = bv && bus.b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitPairs(input int target, input int budget, input string name);
    int c = 0;
    while (obs.size() < target && c < budget) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      c++;
    end
    checkOutput(name, obs.size() >= target, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int base, accA, accB, sent, guard;
    bit found;
    logic [7:0] aVals[3] = '{8'd10, 8'd20, 8'd30};
    logic [7:0] bVals[3] = '{8'd200, 8'd100, 8'd50};
    logic [7:0] word;

    rst_n = 0;
    bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0;
    bus.hold = 0; bus.cfg_load = 0; bus.cfg_mode = 0; bus.cfg_param = 0;
    #2;
    checkOutput("reset a_ready", bus.a_ready, 1);
    checkOutput("reset b_ready", bus.b_ready, 1);
    checkOutput("reset pair_valid", bus.pair_valid, 0);
    checkOutput("reset pix_count", bus.pix_count, 0);
    #30 rst_n = 1;
    @(posedge clk); #1;

    $display("[TB] blend pairing");
    base = obs.size();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, 8'd128);
    for (int t = 0; t < 6; t++)
      applyStimulus(t < 3, (t < 3) ? aVals[t] : 8'd0, t >= 3, (t >= 3) ? bVals[t-3] : 8'd0,
                    0, 0, 0, 0);
    waitPairs(base + 3, 20, "blend three issues");
    for (int i = 0; i < 3 && base + i < obs.size(); i++) begin
      checkOutput("blend pix_t", obs[base+i].t, aVals[i]);
      checkOutput("blend pix_t1", obs[base+i].t1, bVals[i]);
      checkOutput("blend param", obs[base+i].p, 128);
    end

    $display("[TB] backpressure");
    base = obs.size(); accA = 0; accB = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 8'(60 + i), 1, 8'(160 + i), 1, 0, 0, 0);
      accA += int'(aAccLast); accB += int'(bAccLast);
    end
    checkOutput("held A accepts", accA, DEPTH);
    checkOutput("held B accepts", accB, DEPTH);
    checkOutput("no issue while held", obs.size(), base);
    waitPairs(base + 4, 20, "release four issues");
    for (int i = 0; i < 4 && base + i < obs.size(); i++) begin
      checkOutput("backpressure order", obs[base+i].t, 60 + i);
      checkOutput("backpressure consecutive", obs[base+i].cyc, obs[base].cyc + i);
    end

    $display("[TB] mode 01 ignores B");
    applyStimulus(0, 0, 0, 0, 0, 1, 2'b01, 8'h33);
    applyStimulus(1, 8'd1, 1, 8'd2, 0, 0, 0, 0);
    waitPairs(obs.size() + 1, 10, "frame closing issue");
    base = obs.size();
    applyStimulus(1, 8'd99, 1, 8'd7, 0, 0, 0, 0);
    waitPairs(base + 1, 10, "invert issue");
    if (obs.size() > base) begin
      checkOutput("invert pix_t", obs[base].t, 99);
      checkOutput("invert pix_t1", obs[base].t1, 0);
      checkOutput("invert mode", obs[base].m, 1);
    end
    checkOutput("B still buffered", dut.uFifoB.empty_o, 0);
    checkOutput("B head kept", dut.uFifoB.head_o, 7);

    $display("[TB] config deferral");
    applyStimulus(1, 8'd41, 0, 0, 0, 0, 0, 0);
    waitPairs(obs.size() + 1, 10, "index 1 issue");
    applyStimulus(0, 0, 0, 0, 0, 1, 2'b10, 8'd50);
    base = obs.size();
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(42 + i), 0, 0, 0, 0, 0, 0);
    waitPairs(base + 3, 10, "deferral issues");
    if (obs.size() >= base + 3) begin
      checkOutput("idx2 mode kept", obs[base].m, 1);
      checkOutput("idx3 mode kept", obs[base+1].m, 1);
      checkOutput("idx3 frame_end", obs[base+1].fe, 1);
      checkOutput("idx0 index", obs[base+2].idx, 0);
      checkOutput("idx0 new mode", obs[base+2].m, 2);
      checkOutput("idx0 new param", obs[base+2].p, 50);
    end

    $display("[TB] full FIFO streaming");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'($urandom), 0, 0, 1, 0, 0, 0);
    base = obs.size(); sent = 0; guard = 0;
    word = 8'($urandom);
    while (sent < 100 && guard < 1000) begin
      applyStimulus(1, word, 0, 0, 0, 0, 0, 0);
      if (aAccLast) begin sent++; word = 8'($urandom); end
      guard++;
    end
    checkOutput("stream words accepted", sent, 100);
    idle(10);
    checkOutput("stream issue count", obs.size() - base, 100 + DEPTH);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                    2'($urandom), 8'($urandom));
    idle(20);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("[TB] reset mid-frame");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1, 8'($urandom), 1, 8'($urandom), 0, 0, 0, 0);
      if (bus.pair_valid && bus.pix_count == 2) found = 1;
    end
    checkOutput("reached index 2", found, 1);
    checkOutput("A buffered before reset", dut.uFifoA.empty_o, 0);
    bus.a_valid = 0; bus.b_valid = 0;
    rst_n = 0;
    #1;
    checkOutput("rst pix_t", bus.pix_t, 0);
    checkOutput("rst pix_t1", bus.pix_t1, 0);
    checkOutput("rst mode_o", bus.mode_o, 0);
    checkOutput("rst param_o", bus.param_o, 0);
    checkOutput("rst pair_valid", bus.pair_valid, 0);
    checkOutput("rst res_valid", bus.res_valid, 0);
    checkOutput("rst frame_end", bus.frame_end, 0);
    checkOutput("rst pix_count", bus.pix_count, 0);
    checkOutput("rst a_ready", bus.a_ready, 1);
    checkOutput("rst A empty", dut.uFifoA.empty_o, 1);
    checkOutput("rst B empty", dut.uFifoB.empty_o, 1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    base = obs.size();
    applyStimulus(1, 8'd5, 1, 8'd6, 0, 0, 0, 0);
    waitPairs(base + 1, 10, "post-reset issue");
    if (obs.size() > base) begin
      checkOutput("post-reset index", obs[base].idx, 0);
      checkOutput("post-reset mode", obs[base].m, 0);
      checkOutput("post-reset pix_t", obs[base].t, 5);
      checkOutput("post-reset pix_t1", obs[base].t1, 6);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
